// File: rtl/lcd_ctrl.sv
// 4-bit HD44780-style character LCD driver: power-on init, then ready/valid byte writes.
// Define LCD_AUTOWRAP_EN to track the DDRAM address and wrap lines automatically.
module lcd_ctrl #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_WAIT0   = 205000,
  parameter int unsigned T_WAIT1   = 5000,
  parameter int unsigned T_WAIT2   = 2000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 12,
  parameter int unsigned T_GAP     = 50,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned LINE_LEN  = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       write_Enabled,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oLCD_Enabled,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data,
  output logic       oIsInitialized,
  output logic       ready
);

  localparam int unsigned SLOT  = T_SETUP + T_PULSE + 1;
  localparam int unsigned CNT_W = 32;

  // LINE_LEN and 0x40+LINE_LEN must both be reachable by the 7-bit DDRAM address
  if (LINE_LEN == 0 || LINE_LEN > 63) begin : gLineLenCheck
    $error("lcd_ctrl: LINE_LEN must be in 1..63");
  end

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_NIB, INIT_WAIT, CFG, IDLE, NIB_HI, GAP, NIB_LO, BYTE_WAIT
`ifdef LCD_AUTOWRAP_EN
    , WRAP
`endif
  } stateType;

  stateType         state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [7:0]       byteReg, byteNext;
  logic             rsReg, rsNext;
  logic [1:0]       initIdx, initIdxNext;
  logic [1:0]       cfgIdx, cfgIdxNext;
  logic             initDone, initDoneNext;
  logic             eNext, rsOutNext, readyNext;
  logic [3:0]       dataNext;
`ifdef LCD_AUTOWRAP_EN
  logic [6:0]       addr, addrNext;
`endif

  function automatic logic [7:0] cfgByte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic isClearCmd(input logic rs, input logic [7:0] b);
    return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
  endfunction

`ifdef LCD_AUTOWRAP_EN
  function automatic logic [6:0] nextAddr(input logic [6:0] a, input logic rs, input logic [7:0] b);
    if (rs)                 return a + 7'd1;
    else if (isClearCmd(rs, b)) return 7'd0;
    else if (b[7])          return b[6:0];
    else                    return a;
  endfunction
`endif

  // State register, byte/sequence registers and registered pin outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= PWR_WAIT;
      cnt            <= '0;
      byteReg        <= 8'h00;
      rsReg          <= 1'b0;
      initIdx        <= 2'd0;
      cfgIdx         <= 2'd0;
      initDone       <= 1'b0;
      oLCD_Enabled   <= 1'b0;
      oLCD_RS        <= 1'b0;
      oLCD_Data      <= 4'h0;
      oIsInitialized <= 1'b0;
      ready          <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
      addr           <= 7'd0;
`endif
    end else begin
      state          <= stateNext;
      cnt            <= cntNext;
      byteReg        <= byteNext;
      rsReg          <= rsNext;
      initIdx        <= initIdxNext;
      cfgIdx         <= cfgIdxNext;
      initDone       <= initDoneNext;
      oLCD_Enabled   <= eNext;
      oLCD_RS        <= rsOutNext;
      oLCD_Data      <= dataNext;
      oIsInitialized <= initDoneNext;
      ready          <= readyNext;
`ifdef LCD_AUTOWRAP_EN
      addr           <= addrNext;
`endif
    end
  end

  // Next state: each state is held exactly its length, counter restarts on entry
  always_comb begin
    logic [CNT_W-1:0] len;
    logic             done;
    stateNext    = state;
    byteNext     = byteReg;
    rsNext       = rsReg;
    initIdxNext  = initIdx;
    cfgIdxNext   = cfgIdx;
    initDoneNext = initDone;
`ifdef LCD_AUTOWRAP_EN
    addrNext     = addr;
`endif
    case (state)
      PWR_WAIT:                 len = T_POWERUP;
      INIT_NIB, NIB_HI, NIB_LO: len = SLOT;
      INIT_WAIT:                len = (initIdx == 2'd0) ? T_WAIT0 : (initIdx == 2'd1) ? T_WAIT1 : T_WAIT2;
      CFG:                      len = T_WAIT2;
      GAP:                      len = T_GAP;
      BYTE_WAIT:                len = isClearCmd(rsReg, byteReg) ? T_CLEAR : T_CMD;
      default:                  len = 32'd1;
    endcase
    done = (cnt == len - 32'd1);

    case (state)
      PWR_WAIT:  if (done) stateNext = INIT_NIB;
      INIT_NIB:  if (done) stateNext = (initIdx == 2'd3) ? CFG : INIT_WAIT;
      INIT_WAIT: if (done) begin
        stateNext   = INIT_NIB;
        initIdxNext = initIdx + 2'd1;
      end
      // CFG holds the wait after the 0x2 nibble, then launches the first config byte
      CFG: if (done) begin
        stateNext  = NIB_HI;
        byteNext   = cfgByte(2'd0);
        rsNext     = 1'b0;
        cfgIdxNext = 2'd0;
      end
      IDLE: if (write_Enabled) begin
        stateNext = NIB_HI;
        byteNext  = iData;
        rsNext    = iRS;
      end
      NIB_HI: if (done) stateNext = GAP;
      GAP:    if (done) stateNext = NIB_LO;
      NIB_LO: if (done) stateNext = BYTE_WAIT;
      BYTE_WAIT: if (done) begin
        if (!initDone) begin
          if (cfgIdx == 2'd3) begin
            stateNext    = IDLE;
            initDoneNext = 1'b1;
          end else begin
            stateNext  = NIB_HI;
            cfgIdxNext = cfgIdx + 2'd1;
            byteNext   = cfgByte(cfgIdx + 2'd1);
            rsNext     = 1'b0;
          end
        end else begin
          stateNext = IDLE;
`ifdef LCD_AUTOWRAP_EN
          if (rsReg && (addr == 7'(LINE_LEN) || addr == 7'(32'h40 + LINE_LEN)))
            stateNext = WRAP;
`endif
        end
      end
`ifdef LCD_AUTOWRAP_EN
      WRAP: begin
        stateNext = NIB_HI;
        byteNext  = (addr == 7'(LINE_LEN)) ? 8'hC0 : 8'h80;
        rsNext    = 1'b0;
      end
`endif
      default: stateNext = PWR_WAIT;
    endcase

`ifdef LCD_AUTOWRAP_EN
    // Every byte launch (user, config or wrap) updates the address shadow
    if (stateNext == NIB_HI && state != NIB_HI)
      addrNext = nextAddr(addr, rsNext, byteNext);
`endif
    cntNext = (stateNext != state) ? '0 : cnt + 32'd1;
  end

  // Pin values decoded from the upcoming state so they register in step with it
  always_comb begin
    logic pulseWin;
    eNext     = 1'b0;
    rsOutNext = 1'b0;
    dataNext  = 4'h0;
    readyNext = (stateNext == IDLE);
    pulseWin  = (cntNext >= T_SETUP) && (cntNext < T_SETUP + T_PULSE);
    case (stateNext)
      INIT_NIB: begin
        dataNext = (initIdxNext == 2'd3) ? 4'h2 : 4'h3;
        eNext    = pulseWin;
      end
      NIB_HI: begin
        dataNext  = byteNext[7:4];
        rsOutNext = rsNext;
        eNext     = pulseWin;
      end
      NIB_LO: begin
        dataNext  = byteNext[3:0];
        rsOutNext = rsNext;
        eNext     = pulseWin;
      end
      default: ;
    endcase
  end

  assign oLCD_RW                 = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: records every E pulse and compares against a timeline
// computed from the init/byte timing rules (plus the wrap rule under LCD_AUTOWRAP_EN).
module tb_lcd_ctrl;

  localparam int unsigned T_POWERUP = 100;
  localparam int unsigned T_WAIT0   = 40;
  localparam int unsigned T_WAIT1   = 20;
  localparam int unsigned T_WAIT2   = 10;
  localparam int unsigned T_SETUP   = 2;
  localparam int unsigned T_PULSE   = 12;
  localparam int unsigned T_GAP     = 50;
  localparam int unsigned T_CMD     = 30;
  localparam int unsigned T_CLEAR   = 60;
  localparam int unsigned LINE_LEN  = 16;
  localparam int unsigned SLOT      = T_SETUP + T_PULSE + 1;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       write_Enabled = 1'b0;
  logic       iRS = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oLCD_Enabled, oLCD_RS, oLCD_RW, oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;
  logic       oIsInitialized, ready;

  lcd_ctrl #(
    .T_POWERUP(T_POWERUP), .T_WAIT0(T_WAIT0), .T_WAIT1(T_WAIT1), .T_WAIT2(T_WAIT2),
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_GAP(T_GAP), .T_CMD(T_CMD),
    .T_CLEAR(T_CLEAR), .LINE_LEN(LINE_LEN)
  ) dut (
    .Clock(Clock), .Reset(Reset), .write_Enabled(write_Enabled), .iRS(iRS), .iData(iData),
    .oLCD_Enabled(oLCD_Enabled), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl), .oLCD_Data(oLCD_Data),
    .oIsInitialized(oIsInitialized), .ready(ready)
  );

  typedef struct {
    int unsigned rise;
    logic [3:0]  nib;
    logic        rs;
    int unsigned width;
    logic        clean;
  } pulseT;

  pulseT       got[$];
  pulseT       expq[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned fails = 0;
  logic [6:0]  mAddr = 7'd0;

  initial forever #5 Clock = ~Clock;
  initial forever begin @(posedge Clock); cyc++; end

  // Pulse recorder: rise edge, nibble/RS, width, and whether data was steady setup..hold
  initial begin : monitor
    pulseT      cur;
    logic       ePrev;
    logic [3:0] dPrev;
    logic       rPrev;
    cur = '{rise: 0, nib: 4'h0, rs: 1'b0, width: 0, clean: 1'b0};
    ePrev = 1'b0; dPrev = 4'h0; rPrev = 1'b0;
    forever begin
      @(negedge Clock);
      if (oLCD_Enabled && !ePrev) begin
        cur.rise  = cyc;
        cur.nib   = oLCD_Data;
        cur.rs    = oLCD_RS;
        cur.width = 1;
        cur.clean = (dPrev === oLCD_Data) && (rPrev === oLCD_RS);
      end else if (oLCD_Enabled) begin
        cur.width++;
        if (oLCD_Data !== cur.nib || oLCD_RS !== cur.rs) cur.clean = 1'b0;
      end else if (ePrev) begin
        if (oLCD_Data !== cur.nib || oLCD_RS !== cur.rs) cur.clean = 1'b0;
        got.push_back(cur);
      end
      ePrev = oLCD_Enabled; dPrev = oLCD_Data; rPrev = oLCD_RS;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  task automatic expPulse(input int unsigned slotStart, input logic [3:0] nib, input logic rs);
    pulseT p;
    p.rise = slotStart + T_SETUP; p.nib = nib; p.rs = rs; p.width = T_PULSE; p.clean = 1'b1;
    expq.push_back(p);
  endtask

  // One byte launched at slot start t: two nibble slots split by the gap, then settle
  task automatic expectByte(inout int unsigned t, input logic rs, input logic [7:0] b);
    logic [7:0] w;
    expPulse(t, b[7:4], rs);
    expPulse(t + SLOT + T_GAP, b[3:0], rs);
    t += 2 * SLOT + T_GAP + ((!rs && b >= 8'd1 && b <= 8'd3) ? T_CLEAR : T_CMD);
`ifdef LCD_AUTOWRAP_EN
    w = 8'h00;
    if (!rs) begin
      if (b >= 8'd1 && b <= 8'd3) mAddr = 7'd0;
      else if (b[7])              mAddr = b[6:0];
    end else begin
      mAddr = mAddr + 7'd1;
      if (int'(mAddr) == LINE_LEN)             w = 8'hC0;
      else if (int'(mAddr) == 64 + LINE_LEN)   w = 8'h80;
    end
    if (w != 8'h00) begin
      t += 1;
      expPulse(t, w[7:4], 1'b0);
      expPulse(t + SLOT + T_GAP, w[3:0], 1'b0);
      t += 2 * SLOT + T_GAP + T_CMD;
      mAddr = w[6:0];
    end
`else
    w = b;
`endif
  endtask

  task automatic waitReady(input int unsigned limit, output int unsigned at);
    logic ok;
    ok = 1'b0;
    at = 0;
    for (int n = 0; n < int'(limit); n++) begin
      if (ready === 1'b1) begin at = cyc; ok = 1'b1; break; end
      @(negedge Clock);
    end
    if (!ok) begin
      checks++; fails++;
      $error("FAIL ready_timeout: ready not high within %0d cycles", limit);
    end
  endtask

  task automatic checkPulses(input string tag);
    check({tag, "_pulse_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      check($sformatf("%s_rise%0d", tag, i),  got[i].rise,  expq[i].rise);
      check($sformatf("%s_nib%0d", tag, i),   got[i].nib,   expq[i].nib);
      check($sformatf("%s_rs%0d", tag, i),    got[i].rs,    expq[i].rs);
      check($sformatf("%s_width%0d", tag, i), got[i].width, expq[i].width);
      check($sformatf("%s_steady%0d", tag, i), got[i].clean, 1);
    end
    got.delete();
    expq.delete();
  endtask

  // Init timeline from reset release t0 (last edge that saw Reset high)
  task automatic doInit(input int unsigned t0);
    int unsigned t, at;
    int unsigned waits[4];
    waits = '{T_WAIT0, T_WAIT1, T_WAIT2, T_WAIT2};
    mAddr = 7'd0;
    t = t0 + T_POWERUP;
    for (int i = 0; i < 4; i++) begin
      expPulse(t, (i == 3) ? 4'h2 : 4'h3, 1'b0);
      t += SLOT + waits[i];
    end
    expectByte(t, 1'b0, 8'h28);
    expectByte(t, 1'b0, 8'h06);
    expectByte(t, 1'b0, 8'h0C);
    expectByte(t, 1'b0, 8'h01);
    repeat (300) @(negedge Clock);
    check("init_midway_flag", oIsInitialized, 0);
    check("init_midway_ready", ready, 0);
    waitReady(2000, at);
    check("init_ready_cycle", at, t);
    check("init_flag", oIsInitialized, 1);
    check("idle_data", oLCD_Data, 0);
    checkPulses("init");
  endtask

  task automatic doByte(input string tag, input logic rs, input logic [7:0] b, input logic poke);
    int unsigned at, k, t;
    waitReady(600, at);
    write_Enabled = 1'b1; iRS = rs; iData = b;
    @(negedge Clock);
    k = cyc;
    write_Enabled = 1'b0; iData = 8'($urandom); iRS = 1'($urandom);
    check({tag, "_ready_drop"}, ready, 0);
    t = k;
    expectByte(t, rs, b);
    if (poke) begin
      repeat (20) @(negedge Clock);
      write_Enabled = 1'b1; iRS = 1'b0; iData = 8'h01;
      @(negedge Clock);
      write_Enabled = 1'b0;
    end
    waitReady(600, at);
    check({tag, "_ready_return"}, at, t);
    checkPulses(tag);
  endtask

  initial begin : stimulus
    int unsigned t0, at, k, t;
    logic        rs;
    logic [7:0]  b;

    repeat (3) @(negedge Clock);
    check("rst_E", oLCD_Enabled, 0);
    check("rst_RS", oLCD_RS, 0);
    check("rst_RW", oLCD_RW, 0);
    check("rst_SF", oLCD_StrataFlashControl, 1);
    check("rst_data", oLCD_Data, 0);
    check("rst_init", oIsInitialized, 0);
    check("rst_ready", ready, 0);
    Reset = 1'b0;
    t0 = cyc;
    doInit(t0);

    doByte("data41", 1'b1, 8'h41, 1'b0);
    doByte("clear01", 1'b0, 8'h01, 1'b0);
    doByte("cmd0C_poke", 1'b0, 8'h0C, 1'b1);

    // write_Enabled held high across two byte periods
    waitReady(600, at);
    write_Enabled = 1'b1; iRS = 1'b1; iData = 8'h42;
    @(negedge Clock);
    k = cyc;
    iData = 8'h43;
    t = k;
    expectByte(t, 1'b1, 8'h42);
    waitReady(600, at);
    check("b2b_first_ready", at, t);
    @(negedge Clock);
    k = cyc;
    write_Enabled = 1'b0; iData = 8'($urandom);
    check("b2b_second_taken", ready, 0);
    t = k;
    expectByte(t, 1'b1, 8'h43);
    waitReady(600, at);
    check("b2b_second_ready", at, t);
    checkPulses("b2b");

    for (int i = 0; i < 10; i++) begin
      rs = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      if (i % 4 == 0) begin rs = 1'b0; b = 8'($urandom_range(1, 3)); end
      doByte($sformatf("rand%0d", i), rs, b, 1'b0);
    end

    // Reset landing in the gap between nibbles of a byte
    waitReady(600, at);
    write_Enabled = 1'b1; iRS = 1'b1; iData = 8'h55;
    @(negedge Clock);
    k = cyc;
    write_Enabled = 1'b0;
    expPulse(k, 4'h5, 1'b1);
    repeat (30) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("abort_E", oLCD_Enabled, 0);
    check("abort_init", oIsInitialized, 0);
    check("abort_ready", ready, 0);
    check("abort_data", oLCD_Data, 0);
    checkPulses("abort");
    @(negedge Clock);
    Reset = 1'b0;
    t0 = cyc;
    doInit(t0);

`ifdef LCD_AUTOWRAP_EN
    doByte("wrap_clear", 1'b0, 8'h01, 1'b0);
    for (int i = 0; i < 16; i++)
      doByte($sformatf("wrap_ch%0d", i), 1'b1, 8'($urandom_range(32'h20, 32'h7E)), 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
